mem_wb_regfile: RTL and testbench

Writeback end of the 5-stage RV32 pipeline. This block is the write side of the operand path that the decode stage reads. It registers the MEM-stage results (MEM/WB stage register) and selects the writeback result. It owns the 32x32 architectural register file: two combinational read ports feed the decode stage, and one write port is driven by the writeback result. Same-cycle write/read collisions are bypassed, so decode always sees the newest value.

---
 rtl/mem_wb_regfile_pkg.sv | 17 +
 rtl/mem_wb_regfile_regfile.sv | 62 ++++++
 rtl/mem_wb_regfile.sv | 89 ++++++++
 tb/tb_mem_wb_regfile.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_regfile_pkg.sv
// Shared pipeline definitions for the writeback end of the RV32 pipeline.
//   XLEN     : datapath width
//   REGAW    : architectural register address width
//   res_sel_e: writeback result-select encodings carried from MEM to WB
package mem_wb_regfile_pkg;

   localparam int XLEN  = 32;
   localparam int REGAW = 5;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_MEM  = 2'b01,
      RES_PC4  = 2'b10,
      RES_ZERO = 2'b11
   } res_sel_e;

endpackage

// File: rtl/mem_wb_regfile_regfile.sv
// Architectural register file: NREG x XLEN storage, one write port,
// two combinational read ports with same-cycle write bypass.
// Ports:
//   clk, rst           : clock, synchronous active-high reset (clears all regs)
//   we_i, waddr_i      : write enable / address (writes to x0 are dropped)
//   wdata_i            : write data, also the bypass source
//   a1_i, a2_i         : read addresses
//   rd1_o, rd2_o       : read data (x0 reads as zero)
module mem_wb_regfile_regfile
   import mem_wb_regfile_pkg::*;
#(
   parameter int XLEN = mem_wb_regfile_pkg::XLEN,
   parameter int NREG = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we_i,
   input  logic [REGAW-1:0] waddr_i,
   input  logic [XLEN-1:0]  wdata_i,
   input  logic [REGAW-1:0] a1_i,
   input  logic [REGAW-1:0] a2_i,
   output logic [XLEN-1:0]  rd1_o,
   output logic [XLEN-1:0]  rd2_o
);

   logic [XLEN-1:0] regs_q [NREG];
   logic            wr_en;

   // x0 is hardwired: a write aimed at it never reaches the array.
   assign wr_en = we_i && (waddr_i != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Bypass: a value being written this cycle is returned before it lands
   // in the array, so decode always sees the newest value.
   always_comb begin
      rd1_o = regs_q[a1_i];
      if (a1_i == '0) begin
         rd1_o = '0;
      end else if (wr_en && (a1_i == waddr_i)) begin
         rd1_o = wdata_i;
      end
   end

   always_comb begin
      rd2_o = regs_q[a2_i];
      if (a2_i == '0) begin
         rd2_o = '0;
      end else if (wr_en && (a2_i == waddr_i)) begin
         rd2_o = wdata_i;
      end
   end

endmodule

// File: rtl/mem_wb_regfile.sv
// Writeback stage: MEM/WB stage register, result select, and the
// architectural register file it writes.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   regwm, resrcm, alurm,
//   rdatam, pcp4m, rdm          : MEM-stage results captured into WB
//   a1, a2                      : decode read addresses
//   rd1, rd2                    : decode read data (combinational, bypassed)
//   resultw                     : WB selected result (forwarding source)
//   rdw                         : WB destination register
//   regww                       : WB effective write enable (0 for x0)
module mem_wb_regfile
   import mem_wb_regfile_pkg::*;
#(
   parameter int XLEN = mem_wb_regfile_pkg::XLEN,
   parameter int NREG = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             regwm,
   input  logic [1:0]       resrcm,
   input  logic [XLEN-1:0]  alurm,
   input  logic [XLEN-1:0]  rdatam,
   input  logic [XLEN-1:0]  pcp4m,
   input  logic [REGAW-1:0] rdm,
   input  logic [REGAW-1:0] a1,
   input  logic [REGAW-1:0] a2,
   output logic [XLEN-1:0]  rd1,
   output logic [XLEN-1:0]  rd2,
   output logic [XLEN-1:0]  resultw,
   output logic [REGAW-1:0] rdw,
   output logic             regww
);

   logic             regw_q;
   res_sel_e         resrc_q;
   logic [XLEN-1:0]  alur_q;
   logic [XLEN-1:0]  rdata_q;
   logic [XLEN-1:0]  pcp4_q;
   logic [REGAW-1:0] rd_q;

   // ---- MEM / WB stage boundary ----
   always_ff @(posedge clk) begin
      if (rst) begin
         regw_q  <= 1'b0;
         resrc_q <= RES_ALU;
         alur_q  <= '0;
         rdata_q <= '0;
         pcp4_q  <= '0;
         rd_q    <= '0;
      end else begin
         regw_q  <= regwm;
         resrc_q <= res_sel_e'(resrcm);
         alur_q  <= alurm;
         rdata_q <= rdatam;
         pcp4_q  <= pcp4m;
         rd_q    <= rdm;
      end
   end

   always_comb begin
      resultw = '0;
      unique case (resrc_q)
         RES_ALU:  resultw = alur_q;
         RES_MEM:  resultw = rdata_q;
         RES_PC4:  resultw = pcp4_q;
         RES_ZERO: resultw = '0;
      endcase
   end

   assign rdw   = rd_q;
   assign regww = regw_q && (rd_q != '0);

   mem_wb_regfile_regfile #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we_i    (regww),
      .waddr_i (rd_q),
      .wdata_i (resultw),
      .a1_i    (a1),
      .a2_i    (a2),
      .rd1_o   (rd1),
      .rd2_o   (rd2)
   );

endmodule

// File: tb/tb_mem_wb_regfile.sv
module tb_mem_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        regwm;
   logic [1:0]  resrcm;
   logic [31:0] alurm, rdatam, pcp4m;
   logic [4:0]  rdm, a1, a2;
   logic [31:0] rd1, rd2, resultw;
   logic [4:0]  rdw;
   logic        regww;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_wb_regfile dut (
      .clk     (clk),
      .rst     (rst),
      .regwm   (regwm),
      .resrcm  (resrcm),
      .alurm   (alurm),
      .rdatam  (rdatam),
      .pcp4m   (pcp4m),
      .rdm     (rdm),
      .a1      (a1),
      .a2      (a2),
      .rd1     (rd1),
      .rd2     (rd2),
      .resultw (resultw),
      .rdw     (rdw),
      .regww   (regww)
   );

   // Reference model: architectural register contents plus the one
   // instruction currently sitting in writeback.
   logic [31:0] m_regs [32];
   logic        m_regw;
   logic [1:0]  m_sel;
   logic [31:0] m_alu, m_ld, m_pc4;
   logic [4:0]  m_rd;

   function automatic logic [31:0] m_result();
      case (m_sel)
         2'd0:    return m_alu;
         2'd1:    return m_ld;
         2'd2:    return m_pc4;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic m_we();
      return m_regw && (m_rd != 5'd0);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (m_we() && a == m_rd) return m_result();
      return m_regs[a];
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_regw = 1'b0; m_sel = 2'd0; m_alu = 32'd0; m_ld = 32'd0; m_pc4 = 32'd0; m_rd = 5'd0;
      end else begin
         if (m_we()) m_regs[m_rd] = m_result();
         m_regw = regwm; m_sel = resrcm; m_alu = alurm; m_ld = rdatam; m_pc4 = pcp4m; m_rd = rdm;
      end
   endtask

   task automatic check_model();
      check_val("resultw", resultw, m_result());
      check_val("rdw", {27'd0, rdw}, {27'd0, m_rd});
      check_val("regww", {31'd0, regww}, {31'd0, m_we()});
      check_val("rd1", rd1, m_read(a1));
      check_val("rd2", rd2, m_read(a2));
   endtask

   task automatic adv();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      check_model();
      adv();
   endtask

   task automatic drive(input logic r, input logic w, input logic [1:0] s,
                        input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4,
                        input logic [4:0] d, input logic [4:0] ra1, input logic [4:0] ra2);
      rst = r; regwm = w; resrcm = s; alurm = alu; rdatam = ld; pcp4m = pc4;
      rdm = d; a1 = ra1; a2 = ra2;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'hx;
      drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
      adv();
      adv();

      // Reset then read
      drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd0);
      @(negedge clk);
      check_model();
      check_val("rst_rd1", rd1, 32'd0);
      check_val("rst_rd2", rd2, 32'd0);
      check_val("rst_regww", {31'd0, regww}, 32'd0);
      check_val("rst_resultw", resultw, 32'd0);
      adv();

      // ALU writeback to x7
      drive(1'b0, 1'b1, 2'd0, 32'h0000_1234, 32'd0, 32'd0, 5'd7, 5'd0, 5'd0);
      step();
      drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd7, 5'd0);
      @(negedge clk);
      check_model();
      check_val("alu_resultw", resultw, 32'h0000_1234);
      check_val("alu_rdw", {27'd0, rdw}, 32'd7);
      check_val("alu_regww", {31'd0, regww}, 32'd1);
      adv();
      @(negedge clk);
      check_model();
      check_val("alu_rd1_array", rd1, 32'h0000_1234);
      adv();

      // Bypass collision on x9, both ports
      drive(1'b0, 1'b1, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd9, 5'd0, 5'd0);
      step();
      drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd9);
      @(negedge clk);
      check_model();
      check_val("byp_rd1", rd1, 32'hDEAD_BEEF);
      check_val("byp_rd2", rd2, 32'hDEAD_BEEF);
      adv();

      // Source select on x3
      drive(1'b0, 1'b1, 2'd1, 32'd1, 32'h0000_CAFE, 32'h0000_0104, 5'd3, 5'd3, 5'd0);
      step();
      resrcm = 2'd2;
      @(negedge clk);
      check_model();
      check_val("sel_mem", resultw, 32'h0000_CAFE);
      adv();
      resrcm = 2'd3;
      @(negedge clk);
      check_model();
      check_val("sel_pc4", resultw, 32'h0000_0104);
      adv();
      drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd3);
      @(negedge clk);
      check_model();
      check_val("sel_zero", resultw, 32'd0);
      adv();
      @(negedge clk);
      check_model();
      check_val("sel_x3_final", rd1, 32'd0);
      adv();

      // x0 protection
      drive(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      step();
      drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      check_model();
      check_val("x0_regww", {31'd0, regww}, 32'd0);
      check_val("x0_rd1", rd1, 32'd0);
      adv();
      step();

      // Reset mid-stream: x4=0x55 committed, 0xAA discarded
      drive(1'b0, 1'b1, 2'd0, 32'h55, 32'd0, 32'd0, 5'd4, 5'd4, 5'd0);
      step();
      drive(1'b0, 1'b1, 2'd0, 32'hAA, 32'd0, 32'd0, 5'd4, 5'd4, 5'd0);
      step();
      drive(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd4, 5'd4);
      step();
      drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd4, 5'd4);
      @(negedge clk);
      check_model();
      check_val("rstmid_rd1", rd1, 32'd0);
      adv();
      @(negedge clk);
      check_model();
      check_val("rstmid_rd2", rd2, 32'd0);
      adv();

      // Randomized traffic, destinations biased toward a few registers
      for (int n = 0; n < 600; n++) begin
         logic [4:0] d;
         d = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
         drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), 2'($urandom),
               $urandom, $urandom, $urandom, d,
               ($urandom_range(0, 1) != 0) ? d : 5'($urandom),
               ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom_range(0, 7)));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
